// File: rtl/lut_div_radix4_pkg.sv
// Shared types and constants for the radix-4 LUT divider.
// Optional build macro: LUT_DIV_EARLY_TERM_EN (leading-zero skip).
package lut_div_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DIGITS         = DATA_WIDTH_DEF / 2;
    localparam int CNT_W          = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/lut_div_radix4_if.sv
// Request/result bundle between the datapath and the radix-4 divider.
interface lut_div_radix4_if #(
    parameter int DATA_WIDTH = lut_div_pkg::DATA_WIDTH_DEF
);
    logic                  iStart;
    logic [DATA_WIDTH-1:0] iDividend;
    logic [DATA_WIDTH-1:0] iDivisor;
    logic                  oBusy;
    logic                  oDone;
    logic [DATA_WIDTH-1:0] oQuotient;
    logic [DATA_WIDTH-1:0] oRemainder;
    logic                  oDivByZero;

    modport master (
        output iStart, iDividend, iDivisor,
        input  oBusy, oDone, oQuotient, oRemainder, oDivByZero
    );

    modport slave (
        input  iStart, iDividend, iDivisor,
        output oBusy, oDone, oQuotient, oRemainder, oDivByZero
    );
endinterface

// File: rtl/lut_div_radix4_digit_sel.sv
// One radix-4 quotient digit: pick the largest of {3D, 2D, D, 0} not above R'
// and return the digit with the reduced remainder.
module lut_div_digit_sel #(
    parameter int RW = lut_div_pkg::DATA_WIDTH_DEF + 2
) (
    input  logic [RW-1:0] rp,
    input  logic [RW-1:0] d1,
    input  logic [RW-1:0] d2,
    input  logic [RW-1:0] d3,
    output logic [1:0]    digit,
    output logic [RW-1:0] r_next
);

    always_comb begin
        digit  = 2'd0;
        r_next = rp;
        if (rp >= d3) begin
            digit  = 2'd3;
            r_next = rp - d3;
        end else if (rp >= d2) begin
            digit  = 2'd2;
            r_next = rp - d2;
        end else if (rp >= d1) begin
            digit  = 2'd1;
            r_next = rp - d1;
        end
    end

endmodule

// File: rtl/lut_div_radix4.sv
// Iterative unsigned divider retiring one radix-4 digit per clock from a
// {0, D, 2D, 3D} multiples table. Optional macro: LUT_DIV_EARLY_TERM_EN.
module lut_div_radix4
    import lut_div_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    lut_div_radix4_if.slave  bus
);

    localparam int DW     = DATA_WIDTH;
    localparam int RW     = DW + 2;
    localparam int NDIG   = DW / 2;
    localparam int CW     = $clog2(NDIG + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   n_sh_q, n_sh_d;
    logic [RW-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [RW-1:0]   r_q, r_d;
    logic [DW-1:0]   qs_q, qs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   quot_q, quot_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [RW-1:0]   rp, r_nxt;
    logic [1:0]      dig;
    logic [CW-1:0]   zc;
    logic            accept;

    // Partial remainder stays below D, so shifting by 2 never loses bits.
    assign rp = (r_q << 2) | RW'(n_sh_q[DW-1 -: 2]);

    lut_div_digit_sel #(.RW(RW)) u_sel (
        .rp     (rp),
        .d1     (d1_q),
        .d2     (d2_q),
        .d3     (d3_q),
        .digit  (dig),
        .r_next (r_nxt)
    );

`ifdef LUT_DIV_EARLY_TERM_EN
    logic [CW-1:0] lz;
    logic          hit;

    // Skipped groups start the counter ahead; at least one iteration always runs.
    always_comb begin
        lz  = '0;
        hit = 1'b0;
        for (int g = NDIG - 1; g >= 0; g--) begin
            if (!hit && bus.iDividend[2*g +: 2] == 2'b00) lz = lz + CW'(1);
            else                                          hit = 1'b1;
        end
        zc = (lz > CW'(NDIG - 1)) ? CW'(NDIG - 1) : lz;
    end
`else
    assign zc = '0;
`endif

    assign accept = (state_q != CALC) && bus.iStart;

    always_comb begin
        state_d = state_q;
        n_sh_d  = n_sh_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        r_d     = r_q;
        qs_d    = qs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            CALC: begin
                n_sh_d = n_sh_q << 2;
                r_d    = r_nxt;
                qs_d   = (qs_q << 2) | DW'(dig);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    quot_d  = (qs_q << 2) | DW'(dig);
                    rem_d   = r_nxt[DW-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // Accept from IDLE or DONE; the DONE pulse above is left intact.
        if (accept) begin
            if (bus.iDivisor == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                quot_d  = '1;
                rem_d   = bus.iDividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = CALC;
                busy_d  = 1'b1;
                d1_d    = RW'(bus.iDivisor);
                d2_d    = RW'(bus.iDivisor) << 1;
                d3_d    = RW'(bus.iDivisor) + (RW'(bus.iDivisor) << 1);
                r_d     = '0;
                qs_d    = '0;
                n_sh_d  = bus.iDividend << {zc, 1'b0};
                cnt_d   = zc;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            n_sh_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            r_q     <= '0;
            qs_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_sh_q  <= n_sh_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
    assign bus.oQuotient  = quot_q;
    assign bus.oRemainder = rem_q;
    assign bus.oDivByZero = dbz_q;

endmodule

// File: tb/tb_lut_div_radix4.sv
// Directed bench for lut_div_radix4; early-termination vectors run when
// LUT_DIV_EARLY_TERM_EN is defined. Latency = index of the cycle (1 = the
// cycle right after the accept edge) in which oDone is seen high.
module tb_lut_div_radix4;

    localparam int DW     = 16;
    localparam int DIGITS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lut_div_radix4_if #(.DATA_WIDTH(DW)) bus ();

    lut_div_radix4 #(.DATA_WIDTH(DW)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.oBusy) bcyc++;
            if (bus.oDone) break;
        end
    endtask

    task automatic do_op(input logic [DW-1:0] n, input logic [DW-1:0] d,
                         output int lat, output int bcyc);
        @(negedge clk);
        bus.iStart    = 1'b1;
        bus.iDividend = n;
        bus.iDivisor  = d;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        wait_done(lat, bcyc);
    endtask

    function automatic int model_lat(input logic [DW-1:0] n);
        int z;
        z = 0;
`ifdef LUT_DIV_EARLY_TERM_EN
        for (int g = DIGITS - 1; g >= 0; g--) begin
            if (((n >> (2 * g)) & 16'h3) != 0) break;
            z++;
        end
        if (z > DIGITS - 1) z = DIGITS - 1;
`endif
        return DIGITS - z + 1;
    endfunction

    initial begin
        int lat, bcyc, dcnt;
        logic [DW-1:0] n, d;

        bus.iStart    = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_q",    bus.oQuotient, 0);
        chk("rst_r",    bus.oRemainder, 0);
        chk("rst_dbz",  bus.oDivByZero, 0);
        rst_n = 1'b1;

`ifndef LUT_DIV_EARLY_TERM_EN
        do_op(16'd100, 16'd7, lat, bcyc);
        chk("100/7 q",    bus.oQuotient, 14);
        chk("100/7 r",    bus.oRemainder, 2);
        chk("100/7 dbz",  bus.oDivByZero, 0);
        chk("100/7 lat",  lat, DIGITS + 1);
        chk("100/7 busy", bcyc, DIGITS);
        @(negedge clk);
        chk("done_one_cycle", bus.oDone, 0);

        do_op(16'hFFFF, 16'd1, lat, bcyc);
        chk("ffff/1 q", bus.oQuotient, 16'hFFFF);
        chk("ffff/1 r", bus.oRemainder, 0);
        do_op(16'hFFFF, 16'hFFFF, lat, bcyc);
        chk("ffff/ffff q", bus.oQuotient, 1);
        chk("ffff/ffff r", bus.oRemainder, 0);
`endif

        do_op(16'd1234, 16'd0, lat, bcyc);
        chk("div0 q",    bus.oQuotient, 16'hFFFF);
        chk("div0 r",    bus.oRemainder, 1234);
        chk("div0 dbz",  bus.oDivByZero, 1);
        chk("div0 lat",  lat, 1);
        chk("div0 busy", bcyc, 0);
        do_op(16'd10, 16'd3, lat, bcyc);
        chk("10/3 q",   bus.oQuotient, 3);
        chk("10/3 r",   bus.oRemainder, 1);
        chk("10/3 dbz", bus.oDivByZero, 0);

        // Starts during CALC must be ignored; results from 10/3 held meanwhile.
        @(negedge clk);
        bus.iStart = 1'b1; bus.iDividend = 16'd5; bus.iDivisor = 16'd9;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.oDone) dcnt++;
            if (c == 3) begin
                chk("hold q in calc", bus.oQuotient, 3);
                chk("hold r in calc", bus.oRemainder, 1);
            end
            if (c == 2 || c == 4) begin
                bus.iStart = 1'b1; bus.iDividend = 16'd77; bus.iDivisor = 16'd7;
            end else begin
                bus.iStart = 1'b0;
            end
        end
        chk("ignore done count", dcnt, 1);
        chk("5/9 q", bus.oQuotient, 0);
        chk("5/9 r", bus.oRemainder, 5);

        // Back-to-back: second start issued while the first is in DONE.
        do_op(16'd60000, 16'd300, lat, bcyc);
        chk("60000/300 q",   bus.oQuotient, 200);
        chk("60000/300 r",   bus.oRemainder, 0);
        chk("60000/300 lat", lat, model_lat(16'd60000));
        bus.iStart = 1'b1; bus.iDividend = 16'd65535; bus.iDivisor = 16'd256;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        wait_done(lat, bcyc);
        chk("b2b q",   bus.oQuotient, 255);
        chk("b2b r",   bus.oRemainder, 255);
        chk("b2b lat", lat, model_lat(16'd65535));

        @(negedge clk);
        bus.iStart = 1'b1; bus.iDividend = 16'd40000; bus.iDivisor = 16'd3;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        repeat (2) @(negedge clk);
        chk("third busy", bus.oBusy, 1);
        chk("third hold q", bus.oQuotient, 255);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", bus.oBusy, 0);
        chk("mid rst done", bus.oDone, 0);
        chk("mid rst q",    bus.oQuotient, 0);
        chk("mid rst r",    bus.oRemainder, 0);
        chk("mid rst dbz",  bus.oDivByZero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.oDone) dcnt++;
        end
        chk("no done after rst", dcnt, 0);

`ifdef LUT_DIV_EARLY_TERM_EN
        do_op(16'd3, 16'd2, lat, bcyc);
        chk("et 3/2 q",   bus.oQuotient, 1);
        chk("et 3/2 r",   bus.oRemainder, 1);
        chk("et 3/2 lat", lat, 2);
        do_op(16'h0100, 16'd3, lat, bcyc);
        chk("et 256/3 q",   bus.oQuotient, 85);
        chk("et 256/3 r",   bus.oRemainder, 1);
        chk("et 256/3 lat", lat, 6);
        do_op(16'd0, 16'd5, lat, bcyc);
        chk("et 0/5 q",   bus.oQuotient, 0);
        chk("et 0/5 r",   bus.oRemainder, 0);
        chk("et 0/5 lat", lat, 2);
`endif

        // Random sweep against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            n = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            d = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            if (d == 0) d = 16'd1;
            do_op(n, d, lat, bcyc);
            chk("rand q",   bus.oQuotient, n / d);
            chk("rand r",   bus.oRemainder, n % d);
            chk("rand lat", lat, model_lat(n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
